// File: rtl/image_byte_serializer_pkg.sv
// Shared constants and lane helpers for the image byte serializer.
// A pixel pair is packed {B1,G1,R1,B0,G0,R0} with R0 in the low byte.
package image_byte_serializer_pkg;

    localparam int unsigned PAIR_W             = 48;
    localparam int unsigned BYTES_PER_PAIR     = 6;
    localparam int unsigned BYTES_PER_PIXEL    = 3;
    localparam int unsigned DEFAULT_WIDTH      = 768;
    localparam int unsigned DEFAULT_HEIGHT     = 512;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

    // BMP byte order: blue, green, red for each pixel of the pair.
    typedef enum logic [2:0] {
        LANE_B0 = 3'd0,
        LANE_G0 = 3'd1,
        LANE_R0 = 3'd2,
        LANE_B1 = 3'd3,
        LANE_G1 = 3'd4,
        LANE_R1 = 3'd5
    } lane_e;

    function automatic logic [7:0] lane_byte(input logic [PAIR_W-1:0] pair, input lane_e lane);
        logic [7:0] b;
        case (lane)
            LANE_B0: b = pair[23:16];
            LANE_G0: b = pair[15:8];
            LANE_R0: b = pair[7:0];
            LANE_B1: b = pair[47:40];
            LANE_G1: b = pair[39:32];
            LANE_R1: b = pair[31:24];
            default: b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/image_byte_serializer_sync_fifo.sv
// Synchronous FIFO with registered read data: rd_data_o updates on the edge
// that pops the head. Power-of-two DEPTH, synchronous active-high reset.
module image_byte_serializer_sync_fifo #(
    parameter int unsigned DATA_W = 48,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic [DATA_W-1:0]       wr_data_i,
    input  logic                    rd_en_i,
    output logic [DATA_W-1:0]       rd_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [AW:0]       count_d;
    logic              wr_ok;
    logic              rd_ok;

    assign full_o    = (count_q == DEPTH_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = rd_data_q;
    assign wr_ok     = wr_en_i && !full_o;
    assign rd_ok     = rd_en_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            count_q <= count_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule

// File: rtl/image_byte_serializer.sv
// Serializes a 2-pixel-per-cycle RGB888 stream into BMP-order bytes (B,G,R)
// with valid/ready handshake, end-of-row/frame markers and overflow flag.
module image_byte_serializer
    import image_byte_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT     = DEFAULT_HEIGHT,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HSYNC,
    input  logic [7:0] DATA_R0,
    input  logic [7:0] DATA_G0,
    input  logic [7:0] DATA_B0,
    input  logic [7:0] DATA_R1,
    input  logic [7:0] DATA_G1,
    input  logic [7:0] DATA_B1,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_eol,
    output logic       out_last,
    output logic       frame_done,
    output logic       overflow
);

    localparam int unsigned COL_N = BYTES_PER_PIXEL * WIDTH;
    localparam int unsigned COL_W = $clog2(COL_N);
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COL_N - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam lane_e            LANE_LAST = lane_e'(3'(BYTES_PER_PAIR - 1));

    logic [PAIR_W-1:0] wr_pair;
    logic [PAIR_W-1:0] fifo_rd_data;
    logic [CNT_W-1:0]  fifo_used;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              push;
    logic              handshake;
    logic              lane_done;
    logic              hold_load;

    logic              pf_valid_q,   pf_valid_d;
    logic [PAIR_W-1:0] hold_q,       hold_d;
    logic              hold_valid_q, hold_valid_d;
    lane_e             lane_q,       lane_d;
    logic [COL_W-1:0]  col_q,        col_d;
    logic [ROW_W-1:0]  row_q,        row_d;
    logic              frame_done_q, frame_done_d;
    logic              overflow_q,   overflow_d;

    assign wr_pair = {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0};

    // A pair stays counted against FIFO_DEPTH until its last byte is taken,
    // including while it sits in the prefetch or holding register.
    assign fifo_count = fifo_used + CNT_W'(pf_valid_q) + CNT_W'(hold_valid_q);
    assign in_ready   = (fifo_count != DEPTH_CNT) && !fifo_full;
    assign push       = HSYNC && in_ready;

    assign handshake = hold_valid_q && out_ready;
    assign lane_done = handshake && (lane_q == LANE_LAST);
    assign hold_load = pf_valid_q && (!hold_valid_q || lane_done);
    assign fifo_pop  = !fifo_empty && (!pf_valid_q || hold_load);

    assign out_valid  = hold_valid_q;
    assign out_byte   = lane_byte(hold_q, lane_q);
    assign out_eol    = hold_valid_q && (col_q == COL_LAST);
    assign out_last   = out_eol && (row_q == ROW_LAST);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

    image_byte_serializer_sync_fifo #(
        .DATA_W (PAIR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (HCLK),
        .rst_i     (HRESET),
        .wr_en_i   (push),
        .wr_data_i (wr_pair),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_used)
    );

    always_comb begin
        pf_valid_d   = pf_valid_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        lane_d       = lane_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (HSYNC & ~in_ready);

        if (fifo_pop) begin
            pf_valid_d = 1'b1;
        end else if (hold_load) begin
            pf_valid_d = 1'b0;
        end

        if (hold_load) begin
            hold_d       = fifo_rd_data;
            hold_valid_d = 1'b1;
            lane_d       = LANE_B0;
        end else if (lane_done) begin
            hold_valid_d = 1'b0;
            lane_d       = LANE_B0;
        end else if (handshake) begin
            lane_d = lane_e'(lane_q + 3'd1);
        end

        if (handshake) begin
            frame_done_d = out_last;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pf_valid_q   <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            lane_q       <= LANE_B0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            pf_valid_q   <= pf_valid_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            lane_q       <= lane_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_image_byte_serializer.sv
// Scoreboard bench: stimulus queues expected bytes, a negedge monitor checks
// bytes, row/frame markers and frame_done against its own position model.
module tb_image_byte_serializer;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned D = 16;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       HSYNC;
    logic [7:0] DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_eol;
    logic       out_last;
    logic       frame_done;
    logic       overflow;

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;
    int fd_count = 0;
    int mcol     = 0;
    int mrow     = 0;
    bit fd_exp   = 0;
    bit stalled  = 0;
    logic [7:0] exp_q [$];

    always #5 HCLK = ~HCLK;

    image_byte_serializer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSYNC      (HSYNC),
        .DATA_R0    (DATA_R0),
        .DATA_G0    (DATA_G0),
        .DATA_B0    (DATA_B0),
        .DATA_R1    (DATA_R1),
        .DATA_G1    (DATA_G1),
        .DATA_B1    (DATA_B1),
        .in_ready   (in_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_eol    (out_eol),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Presents one pair for a single edge; accepted pairs queue B,G,R per pixel.
    task automatic send(input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
                        input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1,
                        input bit accept);
        HSYNC   = 1'b1;
        DATA_R0 = r0; DATA_G0 = g0; DATA_B0 = b0;
        DATA_R1 = r1; DATA_G1 = g1; DATA_B1 = b1;
        if (accept) begin
            exp_q.push_back(b0); exp_q.push_back(g0); exp_q.push_back(r0);
            exp_q.push_back(b1); exp_q.push_back(g1); exp_q.push_back(r1);
        end
        tick();
        HSYNC = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int limit);
        int n = 0;
        while (out_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_valid required=valid within %0d cycles", nm, limit);
        end
    endtask

    task automatic wait_drain(input string nm, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin : monitor
        bit e_eol, e_last;
        forever begin
            @(negedge HCLK);
            if (HRESET === 1'b1) begin
                exp_q.delete();
                mcol    = 0;
                mrow    = 0;
                fd_exp  = 0;
                stalled = 0;
            end else begin
                chk("frame_done", frame_done, fd_exp);
                if (frame_done === 1'b1) fd_count++;
                fd_exp = 0;
                if (stalled) chk("valid_held", out_valid, 1);
                if (out_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte actual=0x%0h required=none at %0t", out_byte, $time);
                    end else begin
                        e_eol  = (mcol == 3 * W - 1);
                        e_last = e_eol && (mrow == H - 1);
                        chk("byte", out_byte, exp_q[0]);
                        chk("eol", out_eol, e_eol);
                        chk("last", out_last, e_last);
                        if (out_ready === 1'b1) begin
                            void'(exp_q.pop_front());
                            hs_count++;
                            fd_exp = e_last;
                            if (e_eol) begin
                                mcol = 0;
                                mrow = (mrow == H - 1) ? 0 : mrow + 1;
                            end else begin
                                mcol++;
                            end
                        end
                    end
                end
                stalled = (out_valid === 1'b1) && (out_ready !== 1'b1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int hs0, fd0;
        HRESET = 1'b1; HSYNC = 1'b0; out_ready = 1'b0;
        DATA_R0 = '0; DATA_G0 = '0; DATA_B0 = '0;
        DATA_R1 = '0; DATA_G1 = '0; DATA_B1 = '0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        chk("rst_out_valid",  out_valid,  0);
        chk("rst_out_byte",   out_byte,   0);
        chk("rst_out_eol",    out_eol,    0);
        chk("rst_out_last",   out_last,   0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow",   overflow,   0);
        chk("rst_in_ready",   in_ready,   1);

        // Single pair, two-cycle latency, six consecutive bytes.
        out_ready = 1'b1;
        send(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1);
        chk("t1_valid_t0", out_valid, 0);
        tick();
        chk("t1_valid_t1", out_valid, 0);
        tick();
        chk("t1_valid_t2", out_valid, 1);
        chk("t1_first_byte", out_byte, 8'h33);
        hs0 = hs_count;
        repeat (6) tick();
        chk("t1_six_bytes", hs_count - hs0, 6);
        chk("t1_idle", out_valid, 0);

        // Two back-to-back pairs with stall pattern 1,0,0,1.
        out_ready = 1'b0;
        send(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 1);
        send(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 1);
        wait_valid("t2_first_valid", 10);
        hs0 = hs_count;
        for (int i = 0; i < 24; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            tick();
        end
        chk("t2_twelve_bytes", hs_count - hs0, 12);
        chk("t2_idle", out_valid, 0);
        chk("t2_queue_empty", exp_q.size(), 0);

        // Fill with sink stalled; the 17th pair must be dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            chk("t3_in_ready", in_ready, (k < 16));
            send(8'(k), 8'(k + 32), 8'(k + 64), 8'(k + 96), 8'(k + 128), 8'(k + 160), (k < 16));
        end
        chk("t3_overflow", overflow, 1);
        tick();
        tick();
        chk("t3_overflow_sticky", overflow, 1);
        chk("t3_full", in_ready, 0);
        hs0 = hs_count;
        out_ready = 1'b1;
        wait_drain("t3_drain", 300);
        tick();
        chk("t3_96_bytes", hs_count - hs0, 96);
        chk("t3_idle", out_valid, 0);
        chk("t3_overflow_kept", overflow, 1);

        // Reset mid-row with five pairs buffered.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(8'hC0 + 8'(k), 8'hC8, 8'hD0, 8'hD8, 8'hE0, 8'hE8, 1);
        end
        tick();
        tick();
        chk("t5_midrow_valid", out_valid, 1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        chk("t5_valid_cleared", out_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_overflow_cleared", overflow, 0);
        chk("t5_frame_done", frame_done, 0);
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t5_no_stale", out_valid, 0);

        // Full frame of 4x2 plus the first pair of the next frame.
        fd0 = fd_count;
        for (int k = 0; k < 5; k++) begin
            send(8'h80 + 8'(k), 8'h90 + 8'(k), 8'hA0 + 8'(k),
                 8'hB0 + 8'(k), 8'hC0 + 8'(k), 8'hD0 + 8'(k), 1);
        end
        wait_drain("t4_drain", 100);
        tick();
        tick();
        chk("t4_one_frame_done", fd_count - fd0, 1);
        chk("t4_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_byte_serializer.md
Name: image_byte_serializer

Overview:
- Downstream neighbour of the image reader/processor stage.
- Consumes the 2-pixel-per-cycle RGB888 stream (HSYNC-qualified DATA_R0/G0/B0/R1/G1/B1) and buffers it in a small FIFO.
- Serializes the stream into a BMP-order byte stream (B,G,R per pixel) with valid/ready handshake, end-of-row and end-of-frame markers.
- Feeds the image writer / output sink.

Parameters:
- WIDTH, 768, image width in pixels; even, ≥2.
- HEIGHT, 512, image height in rows; ≥1.
- FIFO_DEPTH, 16, pixel-pair entries; power of two, ≥2.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HSYNC  in  1  input-pair valid; one pixel pair per cycle when high.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel.
- in_ready  out  1  FIFO can accept a pair this cycle.
- out_byte  out  8  serialized byte.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts the byte.
- out_eol  out  1  current byte is the last byte of a row.
- out_last  out  1  current byte is the last byte of the frame.
- frame_done  out  1  one-cycle pulse after the final byte handshake.
- overflow  out  1  sticky; a pair was presented while in_ready=0.

Behaviour:
- Reset values:
  - out_valid=0, out_byte=0, out_eol=0, out_last=0, frame_done=0, overflow=0.
  - FIFO empty; byte/row counters 0.
  - in_ready=1 (combinational: fifo_count != FIFO_DEPTH).
- Push: HSYNC && in_ready writes {B1,G1,R1,B0,G0,R0} (48 bits) into the FIFO at the edge.
  - in_ready is computed from the count before any same-cycle pop: no push when full, even if a pop occurs that cycle.
- Drop: HSYNC && !in_ready discards the pair and sets overflow=1 until reset.
- Serializer: 48-bit holding register plus lane index 0..5.
  - Lane order: 0=B0, 1=G0, 2=R0, 3=B1, 4=G1, 5=R1.
  - The holding register loads from the FIFO head when it is empty, or when lane 5 completes a handshake and the FIFO is non-empty.
  - Back-to-back pairs stream without bubbles.
- Latency: a pair pushed at edge t into an empty FIFO with an idle serializer gives out_valid=1 with lane 0 after edge t+2.
- Handshake: a byte transfers when out_valid && out_ready.
  - While out_valid && !out_ready: out_byte, out_eol and out_last hold stable.
  - out_valid never drops without a handshake.
- Counters advance only on handshake:
  - byte_col runs 0..3*WIDTH-1; row runs 0..HEIGHT-1.
  - out_eol = (byte_col == 3*WIDTH-1).
  - out_last = out_eol && (row == HEIGHT-1).
- Frame end:
  - Handshake with out_last=1 → frame_done=1 for exactly the next cycle.
  - byte_col and row wrap to 0; the next frame continues seamlessly.
- Output is in input arrival order. Row inversion is not performed here.
- Reset mid-operation: flushes FIFO and holding register, clears counters and overflow; data from before reset is never emitted.
- The FIFO count width is $clog2(FIFO_DEPTH)+1. The counters are sized from WIDTH/HEIGHT with no truncation.

Decomposition:
- Shared constants go in the common parameter include:
  - pixel-pair width (48)
  - bytes per pair (6)
  - lane order B,G,R
  - default WIDTH/HEIGHT
- One natural sub-module: sync_fifo (parameterised width/depth, synchronous active-high reset, full/empty/count, registered read data).
- Serializer, counters and flags stay in the top.

Test Plan:
1. Single pair R0=0x11 G0=0x22 B0=0x33 R1=0x44 G1=0x55 B1=0x66, out_ready=1 → bytes 0x33,0x22,0x11,0x66,0x55,0x44 on 6 consecutive cycles; first byte valid 2 cycles after the push edge.
2. Two pairs back-to-back, out_ready pattern 1,0,0,1,... → no bubbles, each byte held stable while stalled, 12 bytes in order, no loss.
3. out_ready=0, HSYNC high for 17 cycles, FIFO_DEPTH=16 → in_ready=0 after 16 pushes, 17th pair dropped, overflow=1 sticky. Then out_ready=1 → exactly 96 bytes of the first 16 pairs.
4. WIDTH=4, HEIGHT=2, 4 pairs → 24 bytes; out_eol on bytes 12 and 24; out_last only on byte 24; frame_done pulse one cycle later; next frame's first byte has byte_col=0, row=0.
5. HRESET asserted mid-row with FIFO holding 5 pairs → next cycle out_valid=0, in_ready=1, overflow=0. New stream restarts at lane 0, byte_col 0, row 0.
